// File: rtl/wksg_dec_if.sv
// Decoded-word stream between wksg_dec and its consumer.
// The master side presents x/y and out_valid; the slave side returns out_ready.
interface wksg_dec_if;
  logic [1:0] x;
  logic [1:0] y;
  logic       out_valid;
  logic       out_ready;

  modport master (output x, output y, output out_valid, input out_ready);
  modport slave  (input x, input y, input out_valid, output out_ready);
endinterface

// File: rtl/wksg_dec.sv
// sx/sy line decoder: sync detect, bit-pair deserialisation, FWFT word buffer.
// Define WKSG_DEC_PARITY_EN to add the parity cycle and the frame_err pulse.
module wksg_dec #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sx,
  input  logic                   sy,
  wksg_dec_if.master             stream,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   frame_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  // state | meaning
  // IDLE  | waiting for sync (sx=1, sy=1)
  // BIT1  | sampling x[1]/y[1]
  // BIT0  | sampling x[0]/y[0]
  // PAR   | checking parity cycle (parity build only)
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BIT1 = 2'd1,
    BIT0 = 2'd2
`ifdef WKSG_DEC_PARITY_EN
    , PAR = 2'd3
`endif
  } state_t;

  state_t     state, state_nxt;
  logic       hx, hy;
  logic       push;
  logic [1:0] push_x, push_y;
`ifdef WKSG_DEC_PARITY_EN
  logic       lx, ly;
  logic       perr;
  logic       par;
  logic       frame_err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (state == BIT1) begin
      hx <= sx;
      hy <= sy;
    end
`ifdef WKSG_DEC_PARITY_EN
    if (state == BIT0) begin
      lx <= sx;
      ly <= sy;
    end
`endif
  end

`ifdef WKSG_DEC_PARITY_EN
  assign par = hx ^ lx ^ hy ^ ly;
`endif

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_x    = {hx, sx};
    push_y    = {hy, sy};
`ifdef WKSG_DEC_PARITY_EN
    perr      = 1'b0;
`endif
    case (state)
      IDLE: if (sx && sy) state_nxt = BIT1;
      BIT1: state_nxt = BIT0;
`ifdef WKSG_DEC_PARITY_EN
      BIT0: state_nxt = PAR;
      PAR: begin
        push_x    = {hx, lx};
        push_y    = {hy, ly};
        if ((sx == par) && (sy == ~par)) push = 1'b1;
        else                             perr = 1'b1;
        state_nxt = IDLE;
      end
`else
      BIT0: begin
        push      = 1'b1;
        state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          valid, pop, full, wr_en;

  assign valid = (level != '0);
  assign full  = (level == LVL_FULL);
  assign pop   = valid & stream.out_ready;
  // At full, a simultaneous pop frees the head slot, which is exactly wr_ptr.
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {push_x, push_y};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      overflow <= push & full & ~pop;
    end
  end

`ifdef WKSG_DEC_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) frame_err_q <= 1'b0;
    else     frame_err_q <= perr;
  end
  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

  assign stream.out_valid = valid;
  assign stream.x         = valid ? mem[rd_ptr][3:2] : 2'b00;
  assign stream.y         = valid ? mem[rd_ptr][1:0] : 2'b00;
endmodule

// File: tb/tb_wksg_dec.sv
// Directed self-checking bench for wksg_dec (DEPTH=4); parity steps run
// only when WKSG_DEC_PARITY_EN is defined.
module tb_wksg_dec;
  logic       clk = 1'b0;
  logic       rst, sx, sy;
  logic [2:0] level;
  logic       overflow, frame_err;
  int         total = 0;
  int         passed = 0;

  wksg_dec_if bus ();

  wksg_dec #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .sx(sx), .sy(sy),
    .stream(bus.master),
    .level(level), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drives one full frame; out_ready follows pop_last on the completing cycle.
  task automatic send_frame(input logic [1:0] fx, input logic [1:0] fy,
                            input logic pop_last, input logic bad_par);
    logic p;
    p  = fx[1] ^ fx[0] ^ fy[1] ^ fy[0];
    sx = 1'b1; sy = 1'b1; tick();
    sx = fx[1]; sy = fy[1]; tick();
    sx = fx[0]; sy = fy[0];
`ifdef WKSG_DEC_PARITY_EN
    tick();
    sx = p ^ bad_par; sy = ~(p ^ bad_par);
`endif
    if (pop_last) bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    sx = 1'b0; sy = 1'b0;
  endtask

  initial begin
    logic [1:0] wx [5];
    logic [1:0] wy [5];
    wx[0] = 2'd1; wy[0] = 2'd2;
    wx[1] = 2'd2; wy[1] = 2'd3;
    wx[2] = 2'd3; wy[2] = 2'd0;
    wx[3] = 2'd0; wy[3] = 2'd1;
    wx[4] = 2'd2; wy[4] = 2'd1;

    rst = 1'b1; sx = 1'b0; sy = 1'b0; bus.out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_x", bus.x, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ferr", frame_err, 0);

    // Basic frame, consumer always ready
    bus.out_ready = 1'b1;
    sx = 1'b1; sy = 1'b1; tick();
    sx = 1'b0; sy = 1'b0; tick();
    chk("t1_early_valid", bus.out_valid, 0);
    sx = 1'b1; sy = 1'b0;
`ifdef WKSG_DEC_PARITY_EN
    tick();
    sx = 1'b1; sy = 1'b0;
`endif
    tick();
    sx = 1'b0; sy = 1'b0;
    chk("t1_valid", bus.out_valid, 1);
    chk("t1_x", bus.x, 2'b01);
    chk("t1_y", bus.y, 2'b00);
    tick();
    chk("t1_valid_low", bus.out_valid, 0);
    chk("t1_level0", level, 0);
    chk("t1_x_zero", bus.x, 0);

    // Five words into a four-deep buffer with consumer stalled
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_frame(wx[i], wy[i], 1'b0, 1'b0);
      chk($sformatf("t2_level_%0d", i), level, (i < 4) ? i + 1 : 4);
      chk($sformatf("t2_ovf_%0d", i), overflow, (i == 4) ? 1 : 0);
    end
    tick();
    chk("t2_ovf_clear", overflow, 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_drain_x_%0d", i), bus.x, wx[i]);
      chk($sformatf("t2_drain_y_%0d", i), bus.y, wy[i]);
      tick();
    end
    chk("t2_empty", bus.out_valid, 0);
    chk("t2_level_empty", level, 0);
    bus.out_ready = 1'b0;

    // Full buffer with a pop in the completing cycle; (1,1) data is not resync
    for (int i = 0; i < 4; i++) send_frame(wx[i], wy[i], 1'b0, 1'b0);
    chk("t3_full", level, 4);
    sx = 1'b1; sy = 1'b1; tick();
    sx = 1'b1; sy = 1'b1; tick();
    sx = 1'b1; sy = 1'b1;
`ifdef WKSG_DEC_PARITY_EN
    tick();
    sx = 1'b0; sy = 1'b1;
`endif
    chk("t3_head_before", bus.x, wx[0]);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    sx = 1'b0; sy = 1'b0;
    chk("t3_no_ovf", overflow, 0);
    chk("t3_level", level, 4);
    tick();
    chk("t3_level_idle", level, 4);
    bus.out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("t3_drain_x_%0d", i), bus.x, wx[i]);
      chk($sformatf("t3_drain_y_%0d", i), bus.y, wy[i]);
      tick();
    end
    chk("t3_last_x", bus.x, 2'b11);
    chk("t3_last_y", bus.y, 2'b11);
    tick();
    chk("t3_empty", level, 0);
    bus.out_ready = 1'b0;

    // Reset during BIT0 with one word already queued
    send_frame(2'd3, 2'd2, 1'b0, 1'b0);
    chk("t4_pre_level", level, 1);
    sx = 1'b1; sy = 1'b1; tick();
    sx = 1'b1; sy = 1'b0; tick();
    sx = 1'b0; sy = 1'b1; rst = 1'b1; tick();
    rst = 1'b0; sx = 1'b0; sy = 1'b0;
    chk("t4_valid", bus.out_valid, 0);
    chk("t4_level", level, 0);
    chk("t4_x", bus.x, 0);
    chk("t4_y", bus.y, 0);
    chk("t4_ovf", overflow, 0);
    tick(); tick(); tick();
    chk("t4_no_word", level, 0);
    chk("t4_ferr", frame_err, 0);

`ifdef WKSG_DEC_PARITY_EN
    send_frame(2'b11, 2'b01, 1'b0, 1'b0);
    chk("t5_good_level", level, 1);
    chk("t5_good_ferr", frame_err, 0);
    send_frame(2'b11, 2'b01, 1'b0, 1'b1);
    chk("t5_bad_ferr", frame_err, 1);
    chk("t5_bad_level", level, 1);
    tick();
    chk("t5_ferr_clear", frame_err, 0);
    chk("t5_head_x", bus.x, 2'b11);
    chk("t5_head_y", bus.y, 2'b01);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
